fan_regulator: RTL and testbench
================================

Name: fan_regulator

Overview:
- Control-panel side of the fan drive interface. Produces the `elec` (supply enable) and `mod[2:0]` (speed mode) signals that the fan speed block consumes.
- Turns raw push-button inputs (power, up, down) into a debounced, soft-started and soft-stopped mode sequence.
- Includes mains supervision and an optional auto-off timer.
- Sits between the front-panel buttons and the fan speed block.

Parameters:
- DEB_CYC, 4: consecutive stable synced cycles required to accept a button press or a release.
- DWELL_CYC, 8: cycles spent at each intermediate mode during a ramp.
- TIMER_CYC, 64: cycles in RUN with no button activity before auto-off begins (only when timer_en=1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_pwr  in  1  raw power button, asynchronous, active high.
- btn_up  in  1  raw speed-up button, asynchronous, active high.
- btn_down  in  1  raw speed-down button, asynchronous, active high.
- mains_ok  in  1  supply good; synchronous to clk.
- timer_en  in  1  enables the auto-off timer; level, synchronous.
- elec  out  1  supply enable to the fan block; registered.
- mod  out  3  mode to the fan block: 0 = stopped, 1..3 = speed; registered.
- level  out  2  stored target speed, 1..3; registered.
- busy  out  1  high while ramping; registered.

Behaviour:
- Reset values: elec=0, mod=0, level=1, busy=0, state=OFF, all counters 0, debounce filters in the released state.
- Button input path:
  - Each button passes through a 2-flop synchronizer, then a debounce filter.
  - A press event is a one-cycle pulse, emitted once the synced level has been high for DEB_CYC consecutive cycles.
  - The next press event for that button requires the synced level to have been low for DEB_CYC consecutive cycles first.
  - Holding a button produces exactly one event.
- Latency: raw button rises before edge N and stays high. The event is internal in cycle N+2+DEB_CYC. Outputs change at edge N+3+DEB_CYC.
- Event priority in one cycle: pwr > up > down. Lower-priority events in the same cycle are discarded.
- State OFF:
  - elec=0, mod=0.
  - pwr event with mains_ok=1 -> RAMP_UP; elec=1, mod=1, dwell counter=0.
  - up/down events adjust level (saturating 1..3); outputs unchanged.
- State RAMP_UP:
  - busy=1.
  - When the dwell counter reaches DWELL_CYC-1: if mod<level, mod+1 and the counter clears; else -> RUN.
  - level=1 therefore stays at mod=1 for DWELL_CYC cycles before RUN.
  - up/down adjust level. If level falls below mod, mod=level at once and -> RUN.
  - pwr event -> RAMP_DOWN from the current mod.
- State RUN:
  - busy=0, mod=level.
  - up event: level+1 (saturating at 3). If level increased -> RAMP_UP, stepping from the current mod.
  - down event: level-1 (saturating at 1); mod follows on the next edge with no ramp.
  - pwr event -> RAMP_DOWN.
- State RAMP_DOWN:
  - busy=1.
  - Each DWELL_CYC cycles, mod decrements.
  - When mod=1 and the dwell period expires: mod=0, elec=0 -> OFF.
  - up/down events ignored. pwr event -> RAMP_UP from the current mod.
  - level is preserved; the next power-on ramps to the remembered level.
- Auto-off timer:
  - Counts only in RUN with timer_en=1.
  - Clears on any button event, on leaving RUN, or when timer_en=0.
  - On reaching TIMER_CYC-1 -> RAMP_DOWN.
- Mains supervision:
  - mains_ok=0 in any state has the highest priority, above all events.
  - Next edge: elec=0, mod=0, busy=0, -> OFF; level is kept.
  - A pwr event while mains_ok=0 is discarded.
- Invariants:
  - mod is never 4..7.
  - elec=0 exactly when mod=0.
  - mod never changes by more than 1 per DWELL_CYC cycles when rising.
- Reset mid-ramp returns immediately to the reset values, with no ramp-down.

Decomposition:
- Package fan_pkg holds:
  - mode constants MODE_OFF=0, MODE1=1, MODE2=2, MODE3=3;
  - the state encoding OFF/RAMP_UP/RUN/RAMP_DOWN;
  - the level-saturation limits.
- Sub-module btn_debounce (synchronizer + filter + event pulse), instantiated three times.

Test Plan:
- Power-on ramp. level=3, mains_ok=1; pwr held 10 cycles -> elec=1, mod=1 at edge N+7; mod=2 8 cycles later; mod=3 8 cycles after that; busy falls with state RUN.
- Debounce. pwr glitch high for 3 cycles -> no change. Held 20 cycles -> exactly one event. Re-press after only 2 low cycles -> ignored.
- RUN adjustments. From mod=3, two down presses -> mod 2 then 1, no ramp. Third down -> stays 1. up -> ramp to 2 after 8 cycles.
- Power-off ramp. From RUN mod=3, pwr -> mod 2, 1, 0 at 8-cycle spacing; elec=0 together with mod=0. Next pwr -> ramp back to level=3.
- Mains loss and simultaneous events.
  - mains_ok drops mid RAMP_UP -> elec=0, mod=0 next edge.
  - pwr+up in the same cycle in RUN -> RAMP_DOWN and level unchanged.
- Auto-off and reset. timer_en=1, idle in RUN -> RAMP_DOWN begins at cycle 64. rst pulse during a ramp -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared encodings for the fan control-panel regulator: modes, FSM states, level limits.
package fan_pkg;

    localparam logic [2:0] MODE_OFF = 3'd0;
    localparam logic [2:0] MODE1    = 3'd1;
    localparam logic [2:0] MODE2    = 3'd2;
    localparam logic [2:0] MODE3    = 3'd3;

    localparam logic [1:0] LEVEL_MIN = 2'd1;
    localparam logic [1:0] LEVEL_MAX = 2'd3;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    function automatic logic [1:0] level_inc(input logic [1:0] l);
        return (l >= LEVEL_MAX) ? LEVEL_MAX : l + 2'd1;
    endfunction

    function automatic logic [1:0] level_dec(input logic [1:0] l);
        return (l <= LEVEL_MIN) ? LEVEL_MIN : l - 2'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability filter; emits one pulse per accepted press.
module btn_debounce #(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // Filtered level flips only after DEB_CYC consecutive differing synced samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            if (sync2 != stable) begin
                if (cnt == CW'(DEB_CYC - 1)) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/fan_regulator.sv
// Front-panel fan regulator: debounced buttons drive a soft-start/soft-stop mode FSM.
module fan_regulator
    import fan_pkg::*;
#(
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned DWELL_CYC = 8,
    parameter int unsigned TIMER_CYC = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pwr,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       mains_ok,
    input  logic       timer_en,
    output logic       elec,
    output logic [2:0] mod,
    output logic [1:0] level,
    output logic       busy
);

    localparam int unsigned DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int unsigned TW = (TIMER_CYC > 1) ? $clog2(TIMER_CYC) : 1;

    logic pwr_press;
    logic up_press;
    logic down_press;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_pwr  (.clk(clk), .rst(rst), .raw(btn_pwr),  .press(pwr_press));
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_up   (.clk(clk), .rst(rst), .raw(btn_up),   .press(up_press));
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_down (.clk(clk), .rst(rst), .raw(btn_down), .press(down_press));

    state_t        state, state_n;
    logic          elec_n;
    logic [2:0]    mod_n;
    logic [1:0]    level_n;
    logic          busy_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [TW-1:0] timer, timer_n;

    logic          ev_pwr;
    logic          ev_up;
    logic          ev_dn;
    logic [1:0]    lvl_adj;
    logic [2:0]    lvl_mode;

    assign ev_pwr   = pwr_press;
    assign ev_up    = up_press & ~pwr_press;
    assign ev_dn    = down_press & ~pwr_press & ~up_press;
    assign lvl_adj  = ev_up ? level_inc(level) : (ev_dn ? level_dec(level) : level);
    assign lvl_mode = {1'b0, lvl_adj};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OFF;
            elec  <= 1'b0;
            mod   <= MODE_OFF;
            level <= LEVEL_MIN;
            busy  <= 1'b0;
            dwell <= '0;
            timer <= '0;
        end else begin
            state <= state_n;
            elec  <= elec_n;
            mod   <= mod_n;
            level <= level_n;
            busy  <= busy_n;
            dwell <= dwell_n;
            timer <= timer_n;
        end
    end

    always_comb begin
        state_n = state;
        elec_n  = elec;
        mod_n   = mod;
        level_n = level;
        busy_n  = busy;
        dwell_n = dwell;
        timer_n = '0;

        // Mains loss overrides every button event
        if (!mains_ok) begin
            state_n = OFF;
            elec_n  = 1'b0;
            mod_n   = MODE_OFF;
            busy_n  = 1'b0;
            dwell_n = '0;
        end else begin
            case (state)
                OFF: begin
                    elec_n  = 1'b0;
                    mod_n   = MODE_OFF;
                    busy_n  = 1'b0;
                    dwell_n = '0;
                    if (ev_pwr) begin
                        state_n = RAMP_UP;
                        elec_n  = 1'b1;
                        mod_n   = MODE1;
                        busy_n  = 1'b1;
                    end else begin
                        level_n = lvl_adj;
                    end
                end
                RAMP_UP: begin
                    busy_n = 1'b1;
                    if (ev_pwr) begin
                        state_n = RAMP_DOWN;
                        dwell_n = '0;
                    end else begin
                        level_n = lvl_adj;
                        if (lvl_mode < mod) begin
                            mod_n   = lvl_mode;
                            state_n = RUN;
                            busy_n  = 1'b0;
                            dwell_n = '0;
                        end else if (dwell == DW'(DWELL_CYC - 1)) begin
                            dwell_n = '0;
                            if (mod < lvl_mode) begin
                                mod_n = mod + 3'd1;
                            end else begin
                                state_n = RUN;
                                busy_n  = 1'b0;
                            end
                        end else begin
                            dwell_n = dwell + DW'(1);
                        end
                    end
                end
                RUN: begin
                    busy_n  = 1'b0;
                    mod_n   = {1'b0, level};
                    dwell_n = '0;
                    if (ev_pwr) begin
                        state_n = RAMP_DOWN;
                        busy_n  = 1'b1;
                    end else if (ev_up) begin
                        level_n = lvl_adj;
                        if (lvl_adj != level) begin
                            state_n = RAMP_UP;
                            busy_n  = 1'b1;
                        end
                    end else if (ev_dn) begin
                        level_n = lvl_adj;
                        mod_n   = lvl_mode;
                    end else if (timer_en) begin
                        if (timer == TW'(TIMER_CYC - 1)) begin
                            state_n = RAMP_DOWN;
                            busy_n  = 1'b1;
                        end else begin
                            timer_n = timer + TW'(1);
                        end
                    end
                end
                RAMP_DOWN: begin
                    busy_n = 1'b1;
                    if (ev_pwr) begin
                        state_n = RAMP_UP;
                        dwell_n = '0;
                    end else if (dwell == DW'(DWELL_CYC - 1)) begin
                        dwell_n = '0;
                        if (mod == MODE1) begin
                            mod_n   = MODE_OFF;
                            elec_n  = 1'b0;
                            state_n = OFF;
                            busy_n  = 1'b0;
                        end else begin
                            mod_n = mod - 3'd1;
                        end
                    end else begin
                        dwell_n = dwell + DW'(1);
                    end
                end
                default: begin
                    state_n = OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fan_regulator.sv
// Directed bench for fan_regulator: ramps, debounce, adjustments, mains loss, timer, reset.
module tb_fan_regulator;

    logic       clk;
    logic       rst;
    logic       btn_pwr;
    logic       btn_up;
    logic       btn_down;
    logic       mains_ok;
    logic       timer_en;
    logic       elec;
    logic [2:0] mod;
    logic [1:0] level;
    logic       busy;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    fan_regulator dut (
        .clk      (clk),
        .rst      (rst),
        .btn_pwr  (btn_pwr),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .mains_ok (mains_ok),
        .timer_en (timer_en),
        .elec     (elec),
        .mod      (mod),
        .level    (level),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Hold the chosen buttons for 6 cycles, then release long enough to re-arm the filters
    task automatic press_btn(input logic p, input logic u, input logic d);
        btn_pwr  = p;
        btn_up   = u;
        btn_down = d;
        ticks(6);
        btn_pwr  = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        ticks(8);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        btn_pwr = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        mains_ok = 1'b1; timer_en = 1'b0;
        pass_cnt = 0; fail_cnt = 0; total_cnt = 0;

        #12;
        check("rst_elec",  8'(elec),  8'd0);
        check("rst_mod",   8'(mod),   8'd0);
        check("rst_level", 8'(level), 8'd1);
        check("rst_busy",  8'(busy),  8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ticks(2);

        // Level adjustment while off
        press_btn(1'b0, 1'b1, 1'b0);
        check("off_up1_level", 8'(level), 8'd2);
        press_btn(1'b0, 1'b1, 1'b0);
        check("off_up2_level", 8'(level), 8'd3);
        check("off_mod", 8'(mod), 8'd0);
        check("off_elec", 8'(elec), 8'd0);

        // Power-on ramp to level 3, pwr held 10 cycles
        btn_pwr = 1'b1;
        ticks(7);
        check("on_before_mod", 8'(mod), 8'd0);
        ticks(1);
        check("on_elec", 8'(elec), 8'd1);
        check("on_mod1", 8'(mod), 8'd1);
        check("on_busy", 8'(busy), 8'd1);
        ticks(2);
        btn_pwr = 1'b0;
        ticks(5);
        check("on_mod1_hold", 8'(mod), 8'd1);
        ticks(1);
        check("on_mod2", 8'(mod), 8'd2);
        ticks(8);
        check("on_mod3", 8'(mod), 8'd3);
        ticks(7);
        check("on_busy_late", 8'(busy), 8'd1);
        ticks(1);
        check("run_busy", 8'(busy), 8'd0);
        check("run_mod", 8'(mod), 8'd3);
        check("run_elec", 8'(elec), 8'd1);

        // Short glitch must be rejected
        btn_pwr = 1'b1;
        ticks(3);
        btn_pwr = 1'b0;
        ticks(10);
        check("glitch_mod", 8'(mod), 8'd3);
        check("glitch_busy", 8'(busy), 8'd0);

        // Long hold gives one event; re-press after 2 low cycles is ignored
        btn_pwr = 1'b1;
        ticks(8);
        check("hold_busy", 8'(busy), 8'd1);
        check("hold_mod3", 8'(mod), 8'd3);
        ticks(8);
        check("down_mod2", 8'(mod), 8'd2);
        ticks(4);
        btn_pwr = 1'b0;
        ticks(2);
        btn_pwr = 1'b1;
        ticks(8);
        btn_pwr = 1'b0;
        check("down_mod1", 8'(mod), 8'd1);
        check("down_elec1", 8'(elec), 8'd1);
        ticks(2);
        check("down_mod0", 8'(mod), 8'd0);
        check("down_elec0", 8'(elec), 8'd0);
        check("down_busy0", 8'(busy), 8'd0);
        check("down_level", 8'(level), 8'd3);
        ticks(10);

        // Next power-on returns to remembered level 3
        press_btn(1'b1, 1'b0, 1'b0);
        ticks(17);
        check("reon_busy", 8'(busy), 8'd1);
        ticks(1);
        check("reon_busy0", 8'(busy), 8'd0);
        check("reon_mod3", 8'(mod), 8'd3);

        // RUN adjustments: down steps without ramp, saturate, then up ramps
        press_btn(1'b0, 1'b0, 1'b1);
        check("dn1_mod", 8'(mod), 8'd2);
        check("dn1_busy", 8'(busy), 8'd0);
        press_btn(1'b0, 1'b0, 1'b1);
        check("dn2_mod", 8'(mod), 8'd1);
        press_btn(1'b0, 1'b0, 1'b1);
        check("dn3_mod", 8'(mod), 8'd1);
        check("dn3_level", 8'(level), 8'd1);
        press_btn(1'b0, 1'b1, 1'b0);
        check("up_busy", 8'(busy), 8'd1);
        check("up_level", 8'(level), 8'd2);
        check("up_mod1", 8'(mod), 8'd1);
        ticks(1);
        check("up_mod1_late", 8'(mod), 8'd1);
        ticks(1);
        check("up_mod2", 8'(mod), 8'd2);
        ticks(8);
        check("up_run_busy", 8'(busy), 8'd0);
        check("up_run_mod", 8'(mod), 8'd2);

        // pwr + up together: power wins, level untouched
        press_btn(1'b1, 1'b1, 1'b0);
        check("pu_busy", 8'(busy), 8'd1);
        check("pu_level", 8'(level), 8'd2);
        check("pu_mod", 8'(mod), 8'd2);
        ticks(10);
        check("pu_off_mod", 8'(mod), 8'd0);
        check("pu_off_elec", 8'(elec), 8'd0);

        // Mains loss mid ramp-up
        press_btn(1'b1, 1'b0, 1'b0);
        ticks(3);
        check("ml_mod2", 8'(mod), 8'd2);
        mains_ok = 1'b0;
        ticks(1);
        check("ml_elec", 8'(elec), 8'd0);
        check("ml_mod", 8'(mod), 8'd0);
        check("ml_busy", 8'(busy), 8'd0);
        check("ml_level", 8'(level), 8'd2);
        press_btn(1'b1, 1'b0, 1'b0);
        check("ml_pwr_ignored", 8'(mod), 8'd0);
        mains_ok = 1'b1;
        ticks(2);
        check("ml_restore_mod", 8'(mod), 8'd0);
        check("ml_restore_elec", 8'(elec), 8'd0);

        // Auto-off after 64 idle cycles in RUN
        timer_en = 1'b1;
        press_btn(1'b1, 1'b0, 1'b0);
        ticks(73);
        check("tmr_busy_before", 8'(busy), 8'd0);
        check("tmr_mod_before", 8'(mod), 8'd2);
        ticks(1);
        check("tmr_busy", 8'(busy), 8'd1);
        check("tmr_mod", 8'(mod), 8'd2);

        // Asynchronous reset during the ramp-down
        ticks(3);
        rst = 1'b1;
        #2;
        check("arst_elec", 8'(elec), 8'd0);
        check("arst_mod", 8'(mod), 8'd0);
        check("arst_level", 8'(level), 8'd1);
        check("arst_busy", 8'(busy), 8'd0);
        rst = 1'b0;
        ticks(2);
        check("arst_stay_mod", 8'(mod), 8'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
